// File: rtl/inference_result_collector.sv
// inference_result_collector
//   AXI-Stream sink for the final-layer class scores. Stores every score,
//   tracks the running signed argmax and reports status, predicted class and
//   the stored scores to the processor through an AXI4-Lite slave.
module inference_result_collector #(
  parameter int N_OUTPUTS = 10,
  parameter int DATA_W    = 32,
  parameter int IDX_W     = 6
) (
  input  logic              s_axi_aclk,
  input  logic              s_axi_aresetn,
  input  logic              start,
  input  logic [DATA_W-1:0] y_tdata,
  input  logic              y_tvalid,
  output logic              y_tready,
  input  logic              y_tlast,
  output logic              done,
  output logic [IDX_W-1:0]  pred_class,
  input  logic [11:0]       s_axi_awaddr,
  input  logic [2:0]        s_axi_awprot,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [11:0]       s_axi_araddr,
  input  logic [2:0]        s_axi_arprot,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [31:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready
);

  // Score-bank index width (bank holds exactly N_OUTPUTS words)
  localparam int SEL_W = (N_OUTPUTS > 1) ? $clog2(N_OUTPUTS) : 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  // Capture state
  state_e              state_q, state_d;
  logic [IDX_W-1:0]    count_q, count_d;
  logic [DATA_W-1:0]   max_q, max_d;
  logic [IDX_W-1:0]    pred_q, pred_d;
  logic                err_q, err_d;
  logic                done_q, done_d;
  logic                tready_q, tready_d;
  logic                start_q;
  logic [DATA_W-1:0]   score_q [N_OUTPUTS];

  // AXI4-Lite state
  logic                awready_q, awready_d;
  logic                bvalid_q;
  logic [1:0]          bresp_q;
  logic                arready_q, arready_d;
  logic                rvalid_q;
  logic [31:0]         rdata_q;

  // Combinational helpers
  logic                start_edge_s;
  logic                beat_s;
  logic [IDX_W-1:0]    count_inc_s;
  logic                last_idx_s;
  logic                greater_s;
  logic                score_we_s;
  logic                wr_hs_s;
  logic                wr_ctrl_s;
  logic                clear_s;
  logic                rd_hs_s;
  logic [31:0]         rd_mux_s;
  logic                unused_inputs_s;

  // Inputs that carry no meaning for this slave
  assign unused_inputs_s = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0],
                             s_axi_araddr[1:0], s_axi_wdata[31:2], s_axi_wdata[0]};

  assign start_edge_s = start & ~start_q;
  assign beat_s       = y_tvalid & tready_q & (state_q == ST_COLLECT);
  assign count_inc_s  = count_q + IDX_W'(1);
  assign last_idx_s   = (count_inc_s == IDX_W'(N_OUTPUTS));
  assign greater_s    = ($signed(y_tdata) > $signed(max_q));

  // A write is taken on the edge where the registered ready pulse meets valid
  assign wr_hs_s   = awready_q & s_axi_awvalid & s_axi_wvalid;
  assign wr_ctrl_s = (s_axi_awaddr[11:2] == 10'd0);
  assign clear_s   = wr_hs_s & wr_ctrl_s & (s_axi_wstrb == 4'hF) & s_axi_wdata[1];
  assign rd_hs_s   = arready_q & s_axi_arvalid;

  assign awready_d = s_axi_awvalid & s_axi_wvalid & ~bvalid_q & ~awready_q;
  assign arready_d = s_axi_arvalid & ~rvalid_q & ~arready_q;

  // Next-state logic for the capture FSM, argmax and status; clear overrides last
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    max_d      = max_q;
    pred_d     = pred_q;
    err_d      = err_q;
    done_d     = done_q;
    score_we_s = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_edge_s) begin
          state_d = ST_COLLECT;
          count_d = {IDX_W{1'b0}};
          max_d   = MOST_NEG;
          pred_d  = {IDX_W{1'b0}};
          err_d   = 1'b0;
          done_d  = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      ST_COLLECT: begin
        if (beat_s) begin
          score_we_s = 1'b1;
          count_d    = count_inc_s;
          // First beat always wins; later beats must be strictly greater
          if ((count_q == {IDX_W{1'b0}}) || greater_s) begin
            max_d  = y_tdata;
            pred_d = count_q;
          end else begin
            max_d  = max_q;
          end
          if (y_tlast || last_idx_s) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            err_d   = y_tlast ? ~last_idx_s : 1'b1;
          end else begin
            state_d = ST_COLLECT;
          end
        end else begin
          state_d = ST_COLLECT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (clear_s) begin
      state_d    = ST_IDLE;
      count_d    = {IDX_W{1'b0}};
      done_d     = 1'b0;
      score_we_s = 1'b0;
    end else begin
      score_we_s = score_we_s;
    end
    tready_d = (state_d == ST_COLLECT);
  end

  // Capture FSM and result registers
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q  <= ST_IDLE;
      count_q  <= {IDX_W{1'b0}};
      max_q    <= MOST_NEG;
      pred_q   <= {IDX_W{1'b0}};
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      tready_q <= 1'b0;
      start_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      max_q    <= max_d;
      pred_q   <= pred_d;
      err_q    <= err_d;
      done_q   <= done_d;
      tready_q <= tready_d;
      start_q  <= start;
    end
  end

  // Score bank, deliberately without reset
  always_ff @(posedge s_axi_aclk) begin
    if (score_we_s) begin
      score_q[count_q[SEL_W-1:0]] <= y_tdata;
    end
  end

  // Read address decode for CTRL/STATUS, PRED, COUNT and the score window
  always_comb begin
    rd_mux_s = 32'd0;
    if (s_axi_araddr[11:2] == 10'h000) begin
      rd_mux_s = {28'd0, err_q, (state_q == ST_COLLECT), done_q, 1'b0};
    end else if (s_axi_araddr[11:2] == 10'h001) begin
      rd_mux_s = 32'(pred_q);
    end else if (s_axi_araddr[11:2] == 10'h002) begin
      rd_mux_s = 32'(count_q);
    end else if ((s_axi_araddr[11:8] == 4'h1) &&
                 ({1'b0, s_axi_araddr[7:2]} < 7'(N_OUTPUTS))) begin
      rd_mux_s = 32'(score_q[s_axi_araddr[SEL_W+1:2]]);
    end else begin
      rd_mux_s = 32'd0;
    end
  end

  // AXI4-Lite write address/data acceptance and write response
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      awready_q <= awready_d;
      if (wr_hs_s) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_ctrl_s ? RESP_OKAY : RESP_SLVERR;
      end else if (bvalid_q && s_axi_bready) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  // AXI4-Lite read address acceptance and read data hold
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= 32'd0;
    end else begin
      arready_q <= arready_d;
      if (rd_hs_s) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_mux_s;
      end else if (rvalid_q && s_axi_rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  assign y_tready      = tready_q;
  assign done          = done_q;
  assign pred_class    = pred_q;
  assign s_axi_awready = awready_q;
  assign s_axi_wready  = awready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = RESP_OKAY;

endmodule

// File: tb/tb_inference_result_collector.sv
// Directed bench for inference_result_collector: stream captures, argmax,
// error flag, soft clear, AXI4-Lite responses and mid-capture reset.
module tb_inference_result_collector;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] y_tdata;
  logic        y_tvalid;
  logic        y_tready;
  logic        y_tlast;
  logic        done;
  logic [5:0]  pred_class;
  logic [11:0] awaddr;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic [11:0] araddr;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid, rready;

  int checks   = 0;
  int failures = 0;

  logic [31:0] scores [10];
  logic [31:0] rd_d;
  logic [1:0]  rsp;

  always #5 clk = ~clk;

  inference_result_collector dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (rst_n),
    .start         (start),
    .y_tdata       (y_tdata),
    .y_tvalid      (y_tvalid),
    .y_tready      (y_tready),
    .y_tlast       (y_tlast),
    .done          (done),
    .pred_class    (pred_class),
    .s_axi_awaddr  (awaddr),
    .s_axi_awprot  (3'd0),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_wdata   (wdata),
    .s_axi_wstrb   (wstrb),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_bresp   (bresp),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready),
    .s_axi_araddr  (araddr),
    .s_axi_arprot  (3'd0),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_rdata   (rdata),
    .s_axi_rresp   (rresp),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [11:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [1:0] resp);
    int n;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    while (!awready && n < 20) begin tick(); n++; end
    chk("awready", {31'd0, awready}, 32'd1);
    chk("wready", {31'd0, wready}, 32'd1);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 20) begin tick(); n++; end
    chk("bvalid", {31'd0, bvalid}, 32'd1);
    resp = bresp;
    bready = 1'b1;
    tick();
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [11:0] a, input int hold,
                          output logic [31:0] d, output logic [1:0] resp);
    int n;
    araddr = a; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 20) begin tick(); n++; end
    chk("arready", {31'd0, arready}, 32'd1);
    tick();
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin tick(); n++; end
    chk("rvalid", {31'd0, rvalid}, 32'd1);
    d = rdata; resp = rresp;
    for (int k = 0; k < hold; k++) begin
      tick();
      chk("rvalid_hold", {31'd0, rvalid}, 32'd1);
      chk("rdata_hold", rdata, d);
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    chk("rvalid_clr", {31'd0, rvalid}, 32'd0);
  endtask

  task automatic rd_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic [1:0]  r;
    axi_read(a, 0, d, r);
    chk(tag, d, exp);
    chk({tag, "_rresp"}, {30'd0, r}, 32'd0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Streams scores[0..n-1]; tlast on beat tlast_at (1-based); optional random gaps
  task automatic stream(input int n, input int tlast_at, input int maxgap);
    int w;
    for (int i = 0; i < n; i++) begin
      int g;
      g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
      for (int k = 0; k < g; k++) begin
        y_tvalid = 1'b0;
        tick();
        chk("tready_gap", {31'd0, y_tready}, 32'd1);
      end
      y_tvalid = 1'b1; y_tdata = scores[i]; y_tlast = (i == tlast_at - 1);
      w = 0;
      while (!y_tready && w < 20) begin tick(); w++; end
      chk("tready_beat", {31'd0, y_tready}, 32'd1);
      tick();
    end
    y_tvalid = 1'b0; y_tlast = 1'b0;
  endtask

  task automatic load_mnist_vec();
    scores = '{32'd5, 32'hFFFF_FFFD, 32'd9, 32'd9, 32'd0,
               32'd1, 32'd2, 32'hFFFF_FFF9, 32'd4, 32'd8};
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; y_tdata = 32'd0; y_tvalid = 1'b0; y_tlast = 1'b0;
    awaddr = 12'd0; awvalid = 1'b0; wdata = 32'd0; wstrb = 4'd0; wvalid = 1'b0;
    bready = 1'b0; araddr = 12'd0; arvalid = 1'b0; rready = 1'b0;
    load_mnist_vec();
    tick(); tick();
    chk("rst_tready", {31'd0, y_tready}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_pred", {26'd0, pred_class}, 32'd0);
    chk("rst_awready", {31'd0, awready}, 32'd0);
    chk("rst_arready", {31'd0, arready}, 32'd0);
    chk("rst_bvalid", {31'd0, bvalid}, 32'd0);
    chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    rst_n = 1'b1;
    tick();
    rd_chk("rst_status", 12'h000, 32'd0);
    rd_chk("rst_count", 12'h008, 32'd0);

    // 1: back-to-back capture, ties keep the lower index
    pulse_start();
    chk("t1_tready_armed", {31'd0, y_tready}, 32'd1);
    rd_chk("t1_status_collect", 12'h000, 32'h4);
    stream(10, 10, 0);
    chk("t1_done", {31'd0, done}, 32'd1);
    chk("t1_pred", {26'd0, pred_class}, 32'd2);
    chk("t1_tready_off", {31'd0, y_tready}, 32'd0);
    y_tvalid = 1'b1; y_tdata = 32'd100;
    tick(); tick(); tick();
    y_tvalid = 1'b0;
    rd_chk("t1_status", 12'h000, 32'h2);
    rd_chk("t1_count", 12'h008, 32'd10);
    rd_chk("t1_pred_reg", 12'h004, 32'd2);
    rd_chk("t1_score3", 12'h10C, 32'd9);
    rd_chk("t1_score7", 12'h11C, 32'hFFFF_FFF9);

    // 2: re-arm from DONE, same stream with random valid gaps
    pulse_start();
    chk("t2_done_cleared", {31'd0, done}, 32'd0);
    chk("t2_tready_armed", {31'd0, y_tready}, 32'd1);
    stream(10, 10, 3);
    chk("t2_done", {31'd0, done}, 32'd1);
    chk("t2_pred", {26'd0, pred_class}, 32'd2);
    rd_chk("t2_count", 12'h008, 32'd10);
    rd_chk("t2_status", 12'h000, 32'h2);
    rd_chk("t2_score0", 12'h100, 32'd5);
    rd_chk("t2_score9", 12'h124, 32'd8);

    // 3: all most-negative scores, early tlast on beat 6
    for (int i = 0; i < 10; i++) scores[i] = 32'h8000_0000;
    pulse_start();
    stream(6, 6, 0);
    chk("t3_done", {31'd0, done}, 32'd1);
    chk("t3_pred", {26'd0, pred_class}, 32'd0);
    rd_chk("t3_status_err", 12'h000, 32'hA);
    rd_chk("t3_count", 12'h008, 32'd6);
    rd_chk("t3_score5", 12'h114, 32'h8000_0000);

    // 4: soft clear lands on the same edge as the final beat
    load_mnist_vec();
    pulse_start();
    stream(8, 10, 0);
    y_tvalid = 1'b1; y_tdata = scores[8]; y_tlast = 1'b0;
    awaddr = 12'h000; wdata = 32'h2; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    chk("t4_awready", {31'd0, awready}, 32'd1);
    y_tdata = scores[9]; y_tlast = 1'b1;
    tick();
    y_tvalid = 1'b0; y_tlast = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    chk("t4_done", {31'd0, done}, 32'd0);
    chk("t4_tready", {31'd0, y_tready}, 32'd0);
    chk("t4_bvalid", {31'd0, bvalid}, 32'd1);
    chk("t4_bresp", {30'd0, bresp}, 32'd0);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    rd_chk("t4_count", 12'h008, 32'd0);
    rd_chk("t4_status", 12'h000, 32'd0);

    // 5: SLVERR on non-CTRL write, unmapped read, held read data
    axi_write(12'h004, 32'hFFFF_FFFF, 4'hF, rsp);
    chk("t5_bresp_slverr", {30'd0, rsp}, 32'd2);
    rd_chk("t5_pred_unchanged", 12'h004, 32'd2);
    rd_chk("t5_unmapped", 12'h0F0, 32'd0);
    axi_read(12'h108, 5, rd_d, rsp);
    chk("t5_hold_data", rd_d, 32'd9);
    chk("t5_hold_rresp", {30'd0, rsp}, 32'd0);

    // 6: asynchronous reset in the middle of a capture
    pulse_start();
    stream(4, 10, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_tready", {31'd0, y_tready}, 32'd0);
    chk("t6_rst_done", {31'd0, done}, 32'd0);
    chk("t6_rst_pred", {26'd0, pred_class}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    rd_chk("t6_count_after_rst", 12'h008, 32'd0);
    pulse_start();
    stream(10, 10, 0);
    chk("t6_done", {31'd0, done}, 32'd1);
    chk("t6_pred", {26'd0, pred_class}, 32'd2);
    rd_chk("t6_count", 12'h008, 32'd10);
    rd_chk("t6_status", 12'h000, 32'h2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
